// File: rtl/sysmgr_rst_seq.sv
// Reset/sync sequencer on the fast PLL clock: lock filter, minimum hold, ordered domain release, SERDES sync strobe.
// Build option SYSMGR_RST_SEQ_LOSS_CNT_EN adds a saturating lock-loss event counter.
module sysmgr_rst_seq #(
    parameter int N_DOM     = 3,
    parameter int DIV       = 4,
    parameter int PHASE     = 2,
    parameter int LOCK_FILT = 16,
    parameter int RST_MIN   = 8,
    parameter int DOM_GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             sw_rst,
    output logic             sync,
    output logic [N_DOM-1:0] rst_dom,
    output logic             ready,
    output logic [7:0]       lock_loss_cnt,
    output logic [1:0]       fsm_state
);
    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int HW = (RST_MIN > 1) ? $clog2(RST_MIN) : 1;
    localparam int GW = (DOM_GAP > 1) ? $clog2(DOM_GAP) : 1;

    logic          lock_meta;
    logic          lock_s;
    logic [PW-1:0] pcnt;
    logic [FW-1:0] fcnt;
    logic [HW-1:0] hcnt;
    logic [GW-1:0] gcnt;
    logic [1:0]    state;
    logic          wrap;
    logic          lock_lost;

    assign wrap      = (pcnt == PW'(DIV - 1));
    assign lock_lost = !lock_s && (state != S_WAIT_LOCK);
    assign fsm_state = state;

    // pll_lock is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Phase counter and sync strobe run independently of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            sync <= 1'b0;
        end else begin
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            sync <= (pcnt == PW'(PHASE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT_LOCK;
            fcnt    <= '0;
            hcnt    <= '0;
            gcnt    <= '0;
            rst_dom <= '1;
            ready   <= 1'b0;
        end else if (lock_lost) begin
            state   <= S_WAIT_LOCK;
            fcnt    <= '0;
            rst_dom <= '1;
            ready   <= 1'b0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        fcnt <= '0;
                    end else if (fcnt == FW'(LOCK_FILT - 1)) begin
                        state <= S_HOLD;
                        fcnt  <= '0;
                        hcnt  <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (sw_rst) begin
                        hcnt <= '0;
                    end else if (hcnt == HW'(RST_MIN - 1)) begin
                        state <= S_RELEASE;
                        gcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (sw_rst) begin
                        state   <= S_HOLD;
                        hcnt    <= '0;
                        rst_dom <= '1;
                        ready   <= 1'b0;
                    end else if (wrap) begin
                        if (gcnt == '0) begin
                            // Lowest still-asserted domain drops; the vector empties from bit 0 upward.
                            rst_dom <= rst_dom << 1;
                            gcnt    <= GW'(DOM_GAP - 1);
                            if ((rst_dom << 1) == '0) begin
                                state <= S_RUN;
                                ready <= 1'b1;
                            end
                        end else begin
                            gcnt <= gcnt - 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (sw_rst) begin
                        state   <= S_HOLD;
                        hcnt    <= '0;
                        rst_dom <= '1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef SYSMGR_RST_SEQ_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Self-checking bench for sysmgr_rst_seq: randomized lock/sw_rst stimulus against a rule-level reference model.
// Compile with SYSMGR_RST_SEQ_LOSS_CNT_EN defined to cover the lock-loss counter.
module tb_sysmgr_rst_seq;
    localparam int N_DOM     = 3;
    localparam int DIV       = 4;
    localparam int PHASE     = 2;
    localparam int LOCK_FILT = 16;
    localparam int RST_MIN   = 8;
    localparam int DOM_GAP   = 2;
    localparam int W         = 32;
    localparam int OW        = N_DOM + 10;
`ifdef SYSMGR_RST_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif
    localparam int M_WAIT = 0;
    localparam int M_HOLD = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_lock;
    logic             sw_rst;
    logic             sync;
    logic [N_DOM-1:0] rst_dom;
    logic             ready;
    logic [7:0]       lock_loss_cnt;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    // reference model state: lock pipeline, phase, mode and rule counters
    logic m_meta, m_lock_s, m_sync;
    int   m_phase, m_mode, m_clean, m_hold, m_wraps, m_loss, m_cycle;

    sysmgr_rst_seq #(
        .N_DOM(N_DOM), .DIV(DIV), .PHASE(PHASE),
        .LOCK_FILT(LOCK_FILT), .RST_MIN(RST_MIN), .DOM_GAP(DOM_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_rst(sw_rst),
        .sync(sync), .rst_dom(rst_dom), .ready(ready),
        .lock_loss_cnt(lock_loss_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_meta = 1'b0; m_lock_s = 1'b0; m_sync = 1'b0;
        m_phase = 0; m_mode = M_WAIT; m_clean = 0; m_hold = 0;
        m_wraps = 0; m_loss = 0; m_cycle = 0;
    endtask

    // one rising edge worth of rule application, using pre-edge values
    task automatic model_edge(input logic lk, input logic sw);
        bit wrap_now;
        wrap_now = (m_phase == DIV - 1);
        m_sync   = (m_phase == PHASE);
        m_phase  = (m_phase + 1) % DIV;
        if (m_mode != M_WAIT && !m_lock_s) begin
            m_mode = M_WAIT; m_clean = 0; m_loss++;
        end else if (m_mode == M_WAIT) begin
            if (m_lock_s) begin
                m_clean++;
                if (m_clean == LOCK_FILT) begin m_mode = M_HOLD; m_hold = 0; m_clean = 0; end
            end else begin
                m_clean = 0;
            end
        end else if (m_mode == M_HOLD) begin
            if (sw) m_hold = 0;
            else begin
                m_hold++;
                if (m_hold == RST_MIN) begin m_mode = M_REL; m_wraps = 0; end
            end
        end else if (sw) begin
            m_mode = M_HOLD; m_hold = 0;
        end else if (m_mode == M_REL && wrap_now) begin
            m_wraps++;
            if (m_wraps == (N_DOM - 1) * DOM_GAP + 1) m_mode = M_RUN;
        end
        m_lock_s = m_meta;
        m_meta   = lk;
        m_cycle++;
    endtask

    function automatic logic [N_DOM-1:0] exp_rst();
        logic [N_DOM-1:0] r;
        r = '1;
        for (int i = 0; i < N_DOM; i++)
            if (m_mode == M_RUN || (m_mode == M_REL && m_wraps >= i * DOM_GAP + 1)) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic [7:0] lc;
        lc = !LOSS_EN ? 8'd0 : (m_loss > 255 ? 8'd255 : 8'(m_loss));
        return {m_sync, exp_rst(), (m_mode == M_RUN), lc};
    endfunction

    task automatic step(input logic lk, input logic sw);
        pll_lock = lk;
        sw_rst   = sw;
        @(posedge clk);
        model_edge(lk, sw);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pll_lock = 1'b1; sw_rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (sync !== 1'b0) $display("FAIL reset_sync got=%b exp=0", sync); else n_pass++;
        n_checks++; if (rst_dom !== '1) $display("FAIL reset_rst_dom got=%b exp=%b", rst_dom, {N_DOM{1'b1}}); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else n_pass++;
        n_checks++; if (lock_loss_cnt !== 8'd0) $display("FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt); else n_pass++;
        n_checks++; if (fsm_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", fsm_state); else n_pass++;
    endtask

    task automatic test_release();
        int hold_at = 2 + LOCK_FILT;
        int rel_at  = hold_at + RST_MIN;
        int first_wrap = rel_at + 1;
        int ready_at = -1;
        logic [N_DOM-1:0] prev;
        while (first_wrap % DIV != 0) first_wrap++;
        for (int i = 0; i < N_DOM; i++) exp_q.push_back(W'(first_wrap + i * DOM_GAP * DIV));
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 60; s++) begin
            prev = rst_dom;
            step(1'b1, 1'b0);
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL release_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
            if (m_cycle == hold_at - 1 || m_cycle == hold_at) begin
                n_checks++;
                if (fsm_state !== ((m_cycle == hold_at) ? 2'd1 : 2'd0))
                    $display("FAIL release_hold_entry cycle=%0d got=%0d exp=%0d", m_cycle, fsm_state, (m_cycle == hold_at) ? 1 : 0);
                else n_pass++;
            end
            if (ready === 1'b1 && ready_at < 0) ready_at = m_cycle;
            for (int i = 0; i < N_DOM; i++) begin
                if (prev[i] === 1'b1 && rst_dom[i] === 1'b0) begin
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL release_order dom=%0d cycle=%0d exp=no_release", i, m_cycle);
                    else if (exp_q[0] != W'(m_cycle) || i != N_DOM - exp_q.size())
                        $display("FAIL release_time dom=%0d got=%0d exp=%0d", i, m_cycle, exp_q[0]);
                    else n_pass++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL release_missing got=%0d_pending exp=0", exp_q.size()); else n_pass++;
        n_checks++;
        if (ready_at != first_wrap + (N_DOM - 1) * DOM_GAP * DIV)
            $display("FAIL release_ready got=%0d exp=%0d", ready_at, first_wrap + (N_DOM - 1) * DOM_GAP * DIV);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_sync();
        for (int s = 0; s < 80; s++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
            n_checks++;
            if (sync !== (((m_cycle - 1) % DIV) == PHASE))
                $display("FAIL sync_pulse cycle=%0d got=%b exp=%b", m_cycle, sync, (((m_cycle - 1) % DIV) == PHASE));
            else n_pass++;
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL sync_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lock_glitch();
        int glitch = 11;
        int hold_seen = -1;
        do_reset();
        for (int s = 1; s <= 40; s++) begin
            step(s != glitch, 1'b0);
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL glitch_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
            if (hold_seen < 0 && fsm_state === 2'd1) hold_seen = m_cycle;
        end
        n_checks++;
        if (hold_seen != glitch + 2 + LOCK_FILT)
            $display("FAIL glitch_hold_entry got=%0d exp=%0d", hold_seen, glitch + 2 + LOCK_FILT);
        else n_pass++;
    endtask

    task automatic test_lock_loss_run();
        int n = 0;
        do_reset();
        for (int s = 0; s < 60; s++) step(1'b1, 1'b0);
        n_checks++;
        if (ready !== 1'b1 || rst_dom !== '0) $display("FAIL loss_pre_run got=%b/%b exp=1/000", ready, rst_dom); else n_pass++;
        while (n < 10 && !(rst_dom === '1 && ready === 1'b0)) begin
            step(1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (n < 1 || n > 3) $display("FAIL loss_latency got=%0d exp=1..3", n); else n_pass++;
        n_checks++;
        if (lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) $display("FAIL loss_count_one got=%0d exp=%0d", lock_loss_cnt, LOSS_EN ? 1 : 0); else n_pass++;
        for (int s = 0; s < 70; s++) begin
            step(s >= 5, 1'b0);
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL loss_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_sw_rst_release();
        int guard = 0;
        do_reset();
        while (guard < 100 && exp_rst() != 3'b110) begin step(1'b1, 1'b0); guard++; end
        n_checks++;
        if (rst_dom !== 3'b110) $display("FAIL swrst_partial got=%b exp=110", rst_dom); else n_pass++;
        step(1'b1, 1'b1);
        n_checks++;
        if (rst_dom !== 3'b111 || ready !== 1'b0) $display("FAIL swrst_reassert got=%b/%b exp=111/0", rst_dom, ready); else n_pass++;
        for (int s = 0; s < 60; s++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL swrst_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (ready !== 1'b1) $display("FAIL swrst_rerun got=%b exp=1", ready); else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        do_reset();
        while (guard < 100 && exp_rst() != 3'b100) begin step(1'b1, 1'b0); guard++; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sync, rst_dom, ready, lock_loss_cnt, fsm_state} !== {1'b0, 3'b111, 1'b0, 8'd0, 2'd0})
            $display("FAIL async_reset got=%h exp=%h", {sync, rst_dom, ready, lock_loss_cnt, fsm_state}, {1'b0, 3'b111, 1'b0, 8'd0, 2'd0});
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loss_count();
        do_reset();
        for (int s = 0; s < 20; s++) step(1'b1, 1'b0);
        for (int e = 0; e < 300; e++) begin
            for (int s = 0; s < 21; s++) begin
                step(s != 0, 1'b0);
                n_checks++;
                if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                    $display("FAIL losscnt_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) $display("FAIL losscnt_saturate got=%0d exp=%0d", lock_loss_cnt, LOSS_EN ? 255 : 0); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 3000; s++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 59) == 0));
            n_checks++;
            if ({sync, rst_dom, ready, lock_loss_cnt} !== exp_vec())
                $display("FAIL random_outputs cycle=%0d got=%h exp=%h", m_cycle, {sync, rst_dom, ready, lock_loss_cnt}, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b1; pll_lock = 1'b1; sw_rst = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        test_reset();
        test_release();
        test_sync();
        test_lock_glitch();
        test_lock_loss_run();
        test_sw_rst_release();
        test_async_reset();
        test_loss_count();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
